// File: rtl/output_port_allocator_pkg.sv
// Shared types and helpers for the router output-port allocator:
// lock FSM states, default geometry and the round-robin pick function.
package noc_alloc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    localparam int DEFAULT_PORTS         = 5;
    localparam int DEFAULT_REQUEST_WIDTH = (DEFAULT_PORTS > 1) ? $clog2(DEFAULT_PORTS) : 1;

    typedef struct packed {
        logic                             found;
        logic [DEFAULT_REQUEST_WIDTH-1:0] idx;
    } rr_pick_t;

    // Scan ptr+1, ptr+2, ... (mod ports) and return the first set requester.
    function automatic rr_pick_t rr_pick(
        input logic [DEFAULT_PORTS-1:0]         req_vec,
        input logic [DEFAULT_REQUEST_WIDTH-1:0] ptr
    );
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 1; k <= DEFAULT_PORTS; k++) begin
            c = (int'(ptr) + k) % DEFAULT_PORTS;
            if (!r.found && req_vec[c]) begin
                r.found = 1'b1;
                r.idx   = DEFAULT_REQUEST_WIDTH'(c);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/output_port_allocator_if.sv
// Request/steering bundle between the input buffers, the allocator and the crossbar.
interface output_port_allocator_if
    import noc_alloc_pkg::*;
#(
    parameter int PORTS         = DEFAULT_PORTS,
    parameter int REQUEST_WIDTH = DEFAULT_REQUEST_WIDTH
);
    logic [PORTS-1:0]               req_valid;
    logic [PORTS*REQUEST_WIDTH-1:0] req_port;
    logic [PORTS-1:0]               req_tail;
    logic [PORTS-1:0]               out_ready;
    logic [PORTS-1:0]               in_ready;
    logic [PORTS-1:0]               out_valid;
    logic [PORTS*REQUEST_WIDTH-1:0] out_sel;
    logic [PORTS-1:0]               out_busy;

    modport master (
        output req_valid, req_port, req_tail, out_ready,
        input  in_ready, out_valid, out_sel, out_busy
    );

    modport slave (
        input  req_valid, req_port, req_tail, out_ready,
        output in_ready, out_valid, out_sel, out_busy
    );

endinterface

// File: rtl/output_port_allocator_rr_arbiter.sv
// Per-output wormhole lock: round-robin grant in IDLE, hold the owner until
// its tail flit transfers.
module rr_arbiter
    import noc_alloc_pkg::*;
#(
    parameter int PORTS         = DEFAULT_PORTS,
    parameter int REQUEST_WIDTH = DEFAULT_REQUEST_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         cand,
    input  logic [PORTS-1:0]         req_valid,
    input  logic [PORTS-1:0]         req_tail,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     valid,
    output logic [REQUEST_WIDTH-1:0] sel,
    output logic [PORTS-1:0]         own_mask,
    output logic [PORTS-1:0]         ready_mask
);

    alloc_state_t             state, state_nx;
    logic [REQUEST_WIDTH-1:0] owner, owner_nx;
    logic [REQUEST_WIDTH-1:0] ptr, ptr_nx;
    rr_pick_t                 pick;

    // ptr resets to the last port so input 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= REQUEST_WIDTH'(PORTS - 1);
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        ptr_nx     = ptr;
        pick       = rr_pick(cand, ptr);
        busy       = (state == LOCKED);
        valid      = busy && req_valid[owner];
        sel        = owner;
        own_mask   = '0;
        ready_mask = '0;
        if (busy) begin
            own_mask[owner]   = 1'b1;
            ready_mask[owner] = out_ready;
        end
        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    state_nx = LOCKED;
                    owner_nx = pick.idx;
                    ptr_nx   = pick.idx;
                end
            end
            LOCKED: begin
                if (valid && out_ready && req_tail[owner]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/output_port_allocator.sv
// Switch allocator top: builds per-output candidate masks (excluding inputs
// already owning an output) and merges the per-output steering back together.
module output_port_allocator
    import noc_alloc_pkg::*;
#(
    parameter int PORTS         = DEFAULT_PORTS,
    parameter int REQUEST_WIDTH = DEFAULT_REQUEST_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    output_port_allocator_if.slave bus
);

    logic [PORTS-1:0]         cand       [PORTS];
    logic [PORTS-1:0]         own_mask   [PORTS];
    logic [PORTS-1:0]         ready_mask [PORTS];
    logic [REQUEST_WIDTH-1:0] sel_v      [PORTS];
    logic [PORTS-1:0]         owned;
    logic [PORTS-1:0]         busy_v;
    logic [PORTS-1:0]         valid_v;

    always_comb begin
        owned = '0;
        for (int o = 0; o < PORTS; o++) begin
            owned = owned | own_mask[o];
        end
    end

    // Out-of-range port numbers never match any o, so they are never granted.
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                cand[o][i] = bus.req_valid[i]
                          && (bus.req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o))
                          && !owned[i];
            end
        end
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        rr_arbiter #(
            .PORTS         (PORTS),
            .REQUEST_WIDTH (REQUEST_WIDTH)
        ) u_arb (
            .clk        (clk),
            .rst        (rst),
            .cand       (cand[o]),
            .req_valid  (bus.req_valid),
            .req_tail   (bus.req_tail),
            .out_ready  (bus.out_ready[o]),
            .busy       (busy_v[o]),
            .valid      (valid_v[o]),
            .sel        (sel_v[o]),
            .own_mask   (own_mask[o]),
            .ready_mask (ready_mask[o])
        );
    end

    always_comb begin
        bus.in_ready  = '0;
        bus.out_sel   = '0;
        bus.out_busy  = busy_v;
        bus.out_valid = valid_v;
        for (int o = 0; o < PORTS; o++) begin
            bus.in_ready = bus.in_ready | ready_mask[o];
            bus.out_sel[o*REQUEST_WIDTH +: REQUEST_WIDTH] = sel_v[o];
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: expectations are queued per cycle
// and compared against the steering outputs mid-cycle.
module tb_output_port_allocator;
    import noc_alloc_pkg::*;

    localparam int P  = 5;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_port_allocator_if #(.PORTS(P), .REQUEST_WIDTH(RW)) bus ();

    output_port_allocator #(.PORTS(P), .REQUEST_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {S_READY, S_VALID, S_BUSY, S_SEL} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        int    idx;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   rem[P];

    function automatic int observe(sig_e s, int idx);
        case (s)
            S_READY: return int'(bus.in_ready);
            S_VALID: return int'(bus.out_valid);
            S_BUSY:  return int'(bus.out_busy);
            default: return int'(bus.out_sel[idx*RW +: RW]);
        endcase
    endfunction

    task automatic expect_v(string tag, int ready, int valid, int busy);
        sb.push_back('{tag: {tag, "_in_ready"},  sig: S_READY, idx: 0, val: ready});
        sb.push_back('{tag: {tag, "_out_valid"}, sig: S_VALID, idx: 0, val: valid});
        sb.push_back('{tag: {tag, "_out_busy"},  sig: S_BUSY,  idx: 0, val: busy});
    endtask

    task automatic expect_sel(string tag, int o, int inp);
        sb.push_back('{tag: $sformatf("%s_sel%0d", tag, o), sig: S_SEL, idx: o, val: inp});
    endtask

    task automatic send(int i, int port, int flits);
        rem[i] = flits;
        bus.req_port[i*RW +: RW] = RW'(port);
        bus.req_valid[i] = 1'b1;
        bus.req_tail[i]  = (flits == 1);
    endtask

    // Check the queued expectations for this cycle, then advance one clock and
    // let each input buffer pop the flits that actually transferred.
    task automatic step();
        logic [P-1:0] popped;
        exp_t         e;
        int           obs;
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig, e.idx);
            checks++;
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
        popped = bus.in_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < P; i++) begin
            if (popped[i] && rem[i] > 0) begin
                rem[i]--;
                bus.req_valid[i] = (rem[i] > 0);
                bus.req_tail[i]  = (rem[i] == 1);
            end
        end
    endtask

    int cont_rdy [13] = '{0, 1, 1, 1, 0, 8, 8, 8, 0, 16, 16, 16, 0};
    int cont_busy[13] = '{0, 4, 4, 4, 0, 4, 4, 4, 0, 4, 4, 4, 0};
    int cont_sel [13] = '{0, 0, 0, 0, 0, 3, 3, 3, 3, 4, 4, 4, 4};
    int bp_rdy   [12] = '{0, 2, 0, 0, 0, 0, 2, 2, 2, 2, 2, 0};
    int bp_valid [12] = '{0, 8, 8, 8, 8, 8, 0, 0, 8, 8, 8, 0};
    int bp_busy  [12] = '{0, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 0};

    initial begin
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.req_tail  = '0;
        bus.out_ready = '1;
        for (int i = 0; i < P; i++) rem[i] = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        expect_v("reset", 0, 0, 0);
        for (int o = 0; o < P; o++) expect_sel("reset", o, 0);
        step();

        // Single-flit packet: input 2 -> output 1
        send(2, 1, 1);
        expect_v("single_t0", 0, 0, 0);
        step();
        expect_v("single_t1", 4, 2, 2);
        expect_sel("single_t1", 1, 2);
        step();
        expect_v("single_t2", 0, 0, 0);
        expect_sel("single_t2", 1, 2);
        step();

        // Contention: inputs 0, 3, 4 -> output 2, three flits each
        send(0, 2, 3);
        send(3, 2, 3);
        send(4, 2, 3);
        for (int c = 0; c < 13; c++) begin
            expect_v($sformatf("cont%0d", c), cont_rdy[c], cont_busy[c], cont_busy[c]);
            expect_sel($sformatf("cont%0d", c), 2, cont_sel[c]);
            step();
        end

        // Back-pressure then bubble: input 1 -> output 3, four flits
        send(1, 3, 4);
        for (int c = 0; c < 12; c++) begin
            expect_v($sformatf("bp%0d", c), bp_rdy[c], bp_valid[c], bp_busy[c]);
            expect_sel($sformatf("bp%0d", c), 3, (c == 0) ? 0 : 1);
            step();
            if (c == 1) bus.out_ready[3] = 1'b0;
            if (c == 5) begin
                bus.out_ready[3] = 1'b1;
                bus.req_valid[1] = 1'b0;
            end
            if (c == 7) bus.req_valid[1] = 1'b1;
        end

        // Parallel outputs: 1 -> 0 and 4 -> 3 in the same cycle
        send(1, 0, 1);
        send(4, 3, 1);
        expect_v("par0", 0, 0, 0);
        step();
        expect_v("par1", 18, 9, 9);
        expect_sel("par1", 0, 1);
        expect_sel("par1", 3, 4);
        step();
        expect_v("par2", 0, 0, 0);
        step();

        // Invalid port on input 2 alongside a packet 0 -> 4, reset mid-packet
        send(2, 6, 2);
        send(0, 4, 5);
        expect_v("inv0", 0, 0, 0);
        step();
        expect_v("inv1", 1, 16, 16);
        expect_sel("inv1", 4, 0);
        step();
        expect_v("inv2", 1, 16, 16);
        step();
        rst = 1'b0;
        expect_v("inv3", 1, 16, 16);
        step();
        rst = 1'b1;
        send(0, 4, 1);
        send(3, 4, 1);
        expect_v("post_rst0", 0, 0, 0);
        for (int o = 0; o < P; o++) expect_sel("post_rst0", o, 0);
        step();
        expect_v("post_rst1", 1, 16, 16);
        expect_sel("post_rst1", 4, 0);
        step();
        expect_v("post_rst2", 0, 0, 0);
        step();
        expect_v("post_rst3", 8, 16, 16);
        expect_sel("post_rst3", 4, 3);
        step();
        expect_v("post_rst4", 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Switch allocator for one router: takes the per-input-port routing requests produced by the head-flit decoders and grants each output port to one input port at a time, round-robin. A grant is held for a whole packet, from head flit to tail flit (wormhole). It sits between the input buffers and the crossbar. It drives the crossbar select lines and the flit-level valid/ready steering, and never touches flit data.

## Interface
- PORTS, 5: router ports, both inputs and outputs; index 0 = local port.
- REQUEST_WIDTH, 3: width of one request/select field; must be ≥ $clog2(PORTS).
- clk  in  1: clock; all state updates on rising edge.
- rst  in  1: reset, synchronous, active-low.
- req_valid  in  PORTS: input i has a flit at its buffer head.
- req_port  in  PORTS*REQUEST_WIDTH: field i = requested output port for input i (decoder RequestMessage); stable while req_valid[i] is high and input i is not yet granted.
- req_tail  in  PORTS: flit at the head of input i is a tail flit; a single-flit packet has head = tail.
- out_ready  in  PORTS: downstream of output o can accept a flit.
- in_ready  out  PORTS: pop strobe qualifier for input i.
- out_valid  out  PORTS: flit valid presented on output o.
- out_sel  out  PORTS*REQUEST_WIDTH: field o = input index routed by the crossbar to output o.
- out_busy  out  PORTS: output o is locked to a packet.

## Operation
- Per output o: 2-state FSM IDLE/LOCKED, owner register (REQUEST_WIDTH), round-robin pointer ptr (REQUEST_WIDTH).
- Candidate for o: input i with req_valid[i] set, req_port[i] == o, and input i not owning any output.
- Requests with req_port ≥ PORTS are never granted.
- IDLE: if any candidate exists, the winner is the first candidate in the order ptr+1, ptr+2, … mod PORTS. The next state is LOCKED, owner = winner, ptr = winner.
- LOCKED:
  - out_valid[o] = req_valid[owner]
  - in_ready[owner] = out_ready[o]
  - out_sel[o] = owner
  - out_busy[o] = 1
- Transfer on o: out_valid[o] & out_ready[o].
- Transfer with req_tail[owner] set → IDLE.
- req_valid[owner] may drop mid-packet (bubble); the lock is held.
- An input can own at most one output, because its head flit names exactly one output.
- Unowned input: in_ready = 0.
- IDLE output: out_valid = 0, out_sel holds its last value (0 after reset), out_busy = 0.
- Self-port requests (req_port[i] == i) are legal and arbitrated normally.

## Timing
- Reset (rst = 0 at a clk edge):
  - all FSMs to IDLE, owner = 0, ptr = PORTS-1, so input 0 has first priority;
  - in_ready, out_valid, out_busy, out_sel all 0 from the following cycle;
  - any packet in flight is abandoned.
- Arbitration is registered. A head-flit request visible in cycle t gives out_busy and grant in cycle t+1. The earliest transfer of the head flit is in cycle t+1.
- out_valid, in_ready and out_sel are combinational from state and inputs; no further pipeline.
- Tail transfer in cycle t: IDLE in t+1; re-arbitration in t+1; next grant visible in t+2. The maximum output rate is one packet per (flits+1) cycles.
- Simultaneous events on one output:
  - a tail transfer and a new candidate in the same cycle: the candidate is not granted until the FSM has returned to IDLE;
  - several candidates: exactly one is granted, and the others keep req_valid until served.
- Independent outputs arbitrate in parallel in the same cycle.
- Starvation bound: a continuously requesting input is granted within PORTS-1 packets of other inputs on that output.

## Structure
- Package noc_alloc_pkg:
  - alloc_state_t enum {IDLE, LOCKED};
  - default PORTS;
  - REQUEST_WIDTH derivation;
  - function rr_pick(req_vec, ptr) returning winner index and a found flag.
- Sub-module rr_arbiter (PORTS requesters, pointer plus lock FSM), instantiated once per output. The top level only builds the candidate masks and ORs the per-output in_ready contributions.

## Test plan
- Single-flit packet: input 2 → output 1, req_tail = 1, out_ready = 1.
  - Cycle t+1: out_sel[1] = 2, out_valid[1] = 1, in_ready[2] = 1.
  - Cycle t+2: out_busy[1] = 0.
- Contention: inputs 0, 3 and 4 all request output 2 from reset, each with a 3-flit packet.
  - Grant order is 0, 3, 4.
  - Each lock lasts 3 transfers, with one idle cycle between packets.
- Back-pressure and bubble during a locked packet:
  - out_ready[3] = 0 for 4 cycles mid-packet: in_ready stays 0 and the lock is held;
  - req_valid drops for 2 cycles: out_valid = 0 and out_busy stays 1.
- Parallel outputs: input 1 → output 0 and input 4 → output 3, requested in the same cycle. Both are granted in the next cycle; out_sel[0] = 1 and out_sel[3] = 4.
- Invalid request and reset:
  - req_port = 6 on input 2: never granted, and in_ready[2] stays 0;
  - rst = 0 in mid-packet: the next cycle shows all outputs 0 and ptr = 4;
  - the first request after reset from input 0 wins.
